// File: rtl/regfile_trace_buffer.sv
// regfile_trace_buffer: records register-file writeback events (pc, reg, data) into an armed/triggered trace FIFO.
// Latency: an event sampled at a rising edge is presented on rd_* (show-ahead) right after that edge.
// Backpressure: consumer pops with rd_valid & rd_ready; on full, capture stops (WRAP=0) or overwrites the oldest (WRAP=1).
module regfile_trace_buffer #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 16,
  parameter int WRAP    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     trig_en,
  input  logic [DATA_W-1:0]        trig_pc,
  input  logic                     cmt_valid,
  input  logic [DATA_W-1:0]        cmt_pc,
  input  logic                     cmt_we,
  input  logic [RADDR_W-1:0]       cmt_waddr,
  input  logic [DATA_W-1:0]        cmt_wdata,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [RADDR_W-1:0]       rd_waddr,
  output logic [DATA_W-1:0]        rd_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic [15:0]              dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam bit WRAP_EN = (WRAP != 0);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        dropped_q, dropped_d;
  logic [DATA_W-1:0]  trig_pc_q, trig_pc_d;

  logic [DATA_W-1:0]  mem_pc_q    [DEPTH];
  logic [RADDR_W-1:0] mem_waddr_q [DEPTH];
  logic [DATA_W-1:0]  mem_wdata_q [DEPTH];

  logic qual;       // event worth recording: a real register write, never $0
  logic trig_hit;   // armed and the retiring PC matches the latched trigger
  logic cap_cycle;  // this cycle's event is eligible for recording
  logic full;
  logic pop;
  logic push;       // normal write into a free (or simultaneously freed) slot
  logic ovw;        // circular mode: full, no pop, oldest entry is replaced
  logic drop;
  logic wr_en;

  assign qual      = cmt_valid & cmt_we & (cmt_waddr != '0);
  assign trig_hit  = (state_q == S_ARMED) & cmt_valid & (cmt_pc == trig_pc_q);
  assign cap_cycle = (state_q == S_CAPTURE) | trig_hit;
  assign full      = (count_q == FULL_CNT);
  assign wr_en     = push | ovw;

  // Show-ahead read port; valid depends only on registered occupancy, never on rd_ready.
  assign rd_valid = (count_q != '0);
  assign rd_pc    = rd_valid ? mem_pc_q[rptr_q]    : '0;
  assign rd_waddr = rd_valid ? mem_waddr_q[rptr_q] : '0;
  assign rd_wdata = rd_valid ? mem_wdata_q[rptr_q] : '0;

  assign count   = count_q;
  assign state   = state_q;
  assign dropped = dropped_q;

  // Next-state: arm flushes and restarts; otherwise push/pop/drop bookkeeping and FSM advance.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    dropped_d = dropped_q;
    trig_pc_d = trig_pc_q;
    pop       = 1'b0;
    push      = 1'b0;
    ovw       = 1'b0;
    drop      = 1'b0;

    if (arm) begin
      // Same-cycle events and pops are deliberately ignored so the new session starts clean.
      state_d   = trig_en ? S_ARMED : S_CAPTURE;
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      dropped_d = '0;
      trig_pc_d = trig_pc;
    end else begin
      pop = rd_valid & rd_ready;

      if (cap_cycle && qual) begin
        // A pop in the same cycle frees a slot, so a full buffer can still accept the push.
        if (!full || pop) begin
          push = 1'b1;
        end else begin
          drop = 1'b1;
          ovw  = WRAP_EN;
        end
      end else if ((state_q == S_DONE) && qual) begin
        drop = 1'b1;
      end

      if (push || ovw) wptr_d = wptr_q + PTR_ONE;
      if (pop || ovw)  rptr_d = rptr_q + PTR_ONE;

      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end

      if (drop && (dropped_q != 16'hFFFF)) dropped_d = dropped_q + 16'd1;

      if (trig_hit) state_d = S_CAPTURE;
      // Stop-on-full: the session ends on the edge the buffer fills.
      if (!WRAP_EN && cap_cycle && (count_d == FULL_CNT)) state_d = S_DONE;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      dropped_q <= '0;
      trig_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
      trig_pc_q <= trig_pc_d;
    end
  end

  // Trace storage; contents need no reset because rd_* are masked while empty.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_pc_q[wptr_q]    <= cmt_pc;
      mem_waddr_q[wptr_q] <= cmt_waddr;
      mem_wdata_q[wptr_q] <= cmt_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_trace_buffer.sv
// Bench for regfile_trace_buffer: two DEPTH=4 instances (stop-on-full and circular) share stimulus.
// Directed vector table, hand sequences for wrap/full/reset, then random traffic vs a queue model.
module tb_regfile_trace_buffer;

  logic        clk = 1'b0;
  logic        reset, arm, trig_en, cmt_valid, cmt_we, rd_ready;
  logic [31:0] trig_pc, cmt_pc, cmt_wdata;
  logic [4:0]  cmt_waddr;

  logic        d0_rd_valid, d1_rd_valid;
  logic [31:0] d0_rd_pc, d1_rd_pc, d0_rd_wdata, d1_rd_wdata;
  logic [4:0]  d0_rd_waddr, d1_rd_waddr;
  logic [2:0]  d0_count, d1_count;
  logic [1:0]  d0_state, d1_state;
  logic [15:0] d0_dropped, d1_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_trace_buffer #(.DATA_W(32), .RADDR_W(5), .DEPTH(4), .WRAP(0)) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_we(cmt_we), .cmt_waddr(cmt_waddr),
    .cmt_wdata(cmt_wdata), .rd_ready(rd_ready), .rd_valid(d0_rd_valid), .rd_pc(d0_rd_pc),
    .rd_waddr(d0_rd_waddr), .rd_wdata(d0_rd_wdata), .count(d0_count), .state(d0_state),
    .dropped(d0_dropped));

  regfile_trace_buffer #(.DATA_W(32), .RADDR_W(5), .DEPTH(4), .WRAP(1)) dut1 (
    .clk(clk), .reset(reset), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_we(cmt_we), .cmt_waddr(cmt_waddr),
    .cmt_wdata(cmt_wdata), .rd_ready(rd_ready), .rd_valid(d1_rd_valid), .rd_pc(d1_rd_pc),
    .rd_waddr(d1_rd_waddr), .rd_wdata(d1_rd_wdata), .count(d1_count), .state(d1_state),
    .dropped(d1_dropped));

  typedef struct {
    logic [31:0] arm, ten, tpc, cv, pc, we, wa, wd, rr;
    logic [31:0] e_cnt, e_st, e_dr, e_vld, e_pc, e_wa, e_wd;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;

  // Reference model: per-instance queue of recorded entries plus session state.
  ent_t        mq0[$];
  ent_t        mq1[$];
  int          mst[2];
  int          mdr[2];
  logic [31:0] mtrig[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_dut(input int w, input string tag,
                         input logic [31:0] cnt, input logic [31:0] st, input logic [31:0] dr,
                         input logic [31:0] vld, input logic [31:0] pc, input logic [31:0] wa,
                         input logic [31:0] wd);
    if (w == 0) begin
      chk({tag, " d0 count"},   32'(d0_count),    cnt);
      chk({tag, " d0 state"},   32'(d0_state),    st);
      chk({tag, " d0 dropped"}, 32'(d0_dropped),  dr);
      chk({tag, " d0 rd_valid"},32'(d0_rd_valid), vld);
      chk({tag, " d0 rd_pc"},   d0_rd_pc,         pc);
      chk({tag, " d0 rd_waddr"},32'(d0_rd_waddr), wa);
      chk({tag, " d0 rd_wdata"},d0_rd_wdata,      wd);
    end else begin
      chk({tag, " d1 count"},   32'(d1_count),    cnt);
      chk({tag, " d1 state"},   32'(d1_state),    st);
      chk({tag, " d1 dropped"}, 32'(d1_dropped),  dr);
      chk({tag, " d1 rd_valid"},32'(d1_rd_valid), vld);
      chk({tag, " d1 rd_pc"},   d1_rd_pc,         pc);
      chk({tag, " d1 rd_waddr"},32'(d1_rd_waddr), wa);
      chk({tag, " d1 rd_wdata"},d1_rd_wdata,      wd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    reset = 1'b0; arm = 1'b0; trig_en = 1'b0; trig_pc = '0;
    cmt_valid = 1'b0; cmt_pc = '0; cmt_we = 1'b0; cmt_waddr = '0; cmt_wdata = '0;
    rd_ready = 1'b0;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    cmt_valid = 1'b1; cmt_we = 1'b1; cmt_pc = pc; cmt_waddr = wa; cmt_wdata = wd;
  endtask

  task automatic do_arm(input logic ten, input logic [31:0] tpc);
    clr_in();
    arm = 1'b1; trig_en = ten; trig_pc = tpc;
    tick();
    clr_in();
  endtask

  // Advances one model instance by the edge about to happen, using the current inputs.
  task automatic model_step(input int w);
    ent_t q[$];
    ent_t e;
    int   st;
    bit   qual, hit, rec, full, pop;
    if (w == 0) q = mq0; else q = mq1;
    st = mst[w];
    e.pc = cmt_pc; e.wa = cmt_waddr; e.wd = cmt_wdata;
    if (reset) begin
      q.delete(); mst[w] = 0; mdr[w] = 0;
    end else if (arm) begin
      q.delete(); mdr[w] = 0; mst[w] = trig_en ? 1 : 2; mtrig[w] = trig_pc;
    end else begin
      qual = cmt_valid && cmt_we && (cmt_waddr != 5'd0);
      hit  = (st == 1) && cmt_valid && (cmt_pc == mtrig[w]);
      rec  = (st == 2) || hit;
      full = (q.size() == 4);
      pop  = (q.size() != 0) && rd_ready;
      if (pop) void'(q.pop_front());
      if (hit) mst[w] = 2;
      if (rec && qual) begin
        if (!full || pop) begin
          q.push_back(e);
        end else begin
          mdr[w]++;
          if (w == 1) begin
            void'(q.pop_front());
            q.push_back(e);
          end
        end
      end else if ((st == 3) && qual) begin
        mdr[w]++;
      end
      if ((w == 0) && rec && (q.size() == 4)) mst[w] = 3;
      if (mdr[w] > 65535) mdr[w] = 65535;
    end
    if (w == 0) mq0 = q; else mq1 = q;
  endtask

  vec_t tv[24];

  initial begin
    // Table: stop-on-full instance. Fields: arm,ten,tpc,cv,pc,we,wa,wd,rr | cnt,st,dr,vld,pc,wa,wd
    tv[0]  = '{1,0,0,         0,0,0,0,0,0,               0,2,0,0,0,0,0};
    tv[1]  = '{0,0,0,         1,'h400,1,8,'h11,0,        1,2,0,1,'h400,8,'h11};
    tv[2]  = '{0,0,0,         1,'h404,1,0,'h22,0,        1,2,0,1,'h400,8,'h11};
    tv[3]  = '{0,0,0,         1,'h408,1,9,'h33,0,        2,2,0,1,'h400,8,'h11};
    tv[4]  = '{0,0,0,         0,0,0,0,0,1,               1,2,0,1,'h408,9,'h33};
    tv[5]  = '{0,0,0,         0,0,0,0,0,1,               0,2,0,0,0,0,0};
    tv[6]  = '{1,0,0,         0,0,0,0,0,0,               0,2,0,0,0,0,0};
    tv[7]  = '{0,0,0,         1,'h504,1,1,1,0,           1,2,0,1,'h504,1,1};
    tv[8]  = '{0,0,0,         1,'h508,1,2,2,0,           2,2,0,1,'h504,1,1};
    tv[9]  = '{0,0,0,         1,'h50c,1,3,3,0,           3,2,0,1,'h504,1,1};
    tv[10] = '{0,0,0,         1,'h510,1,4,4,0,           4,3,0,1,'h504,1,1};
    tv[11] = '{0,0,0,         1,'h514,1,5,5,0,           4,3,1,1,'h504,1,1};
    tv[12] = '{0,0,0,         1,'h518,1,6,6,0,           4,3,2,1,'h504,1,1};
    tv[13] = '{0,0,0,         0,0,0,0,0,1,               3,3,2,1,'h508,2,2};
    tv[14] = '{0,0,0,         0,0,0,0,0,1,               2,3,2,1,'h50c,3,3};
    tv[15] = '{0,0,0,         0,0,0,0,0,1,               1,3,2,1,'h510,4,4};
    tv[16] = '{0,0,0,         0,0,0,0,0,1,               0,3,2,0,0,0,0};
    tv[17] = '{1,1,'h3010,    0,0,0,0,0,0,               0,1,0,0,0,0,0};
    tv[18] = '{0,0,0,         1,'h3000,1,5,'ha0,0,       0,1,0,0,0,0,0};
    tv[19] = '{0,0,0,         1,'h3004,1,6,'ha1,0,       0,1,0,0,0,0,0};
    tv[20] = '{0,0,0,         1,'h3010,1,7,'ha2,0,       1,2,0,1,'h3010,7,'ha2};
    tv[21] = '{0,0,0,         1,'h3014,1,10,'ha3,0,      2,2,0,1,'h3010,7,'ha2};
    tv[22] = '{0,0,0,         0,0,0,0,0,1,               1,2,0,1,'h3014,10,'ha3};
    tv[23] = '{0,0,0,         0,0,0,0,0,1,               0,2,0,0,0,0,0};

    clr_in();
    reset = 1'b1;
    tick();
    tick();
    chk_dut(0, "reset", 0, 0, 0, 0, 0, 0, 0);
    chk_dut(1, "reset", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      arm = tv[i].arm[0]; trig_en = tv[i].ten[0]; trig_pc = tv[i].tpc;
      cmt_valid = tv[i].cv[0]; cmt_pc = tv[i].pc; cmt_we = tv[i].we[0];
      cmt_waddr = tv[i].wa[4:0]; cmt_wdata = tv[i].wd; rd_ready = tv[i].rr[0];
      tick();
      chk_dut(0, $sformatf("vec%0d", i), tv[i].e_cnt, tv[i].e_st, tv[i].e_dr,
              tv[i].e_vld, tv[i].e_pc, tv[i].e_wa, tv[i].e_wd);
    end
    clr_in();

    // Six commits into both instances with no pops: stop keeps 1..4, circular keeps 3..6.
    do_arm(1'b0, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      commit(32'h600 + 32'(4 * i), 5'(i), 32'(i));
      tick();
    end
    clr_in();
    chk("six stop state", 32'(d0_state), 3);
    chk("six stop dropped", 32'(d0_dropped), 2);
    chk("six stop count", 32'(d0_count), 4);
    chk("six wrap state", 32'(d1_state), 2);
    chk("six wrap dropped", 32'(d1_dropped), 2);
    chk("six wrap count", 32'(d1_count), 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("six stop drain%0d", k), d0_rd_wdata, 32'(1 + k));
      chk($sformatf("six wrap drain%0d", k), d1_rd_wdata, 32'(3 + k));
      chk($sformatf("six wrap drain%0d pc", k), d1_rd_pc, 32'h600 + 32'(4 * (3 + k)));
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0;
    chk("six stop empty", 32'(d0_rd_valid), 0);
    chk("six wrap empty", 32'(d1_rd_valid), 0);

    // Circular instance, full, push together with pop: accepted, not dropped, order kept.
    do_arm(1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      commit(32'h700 + 32'(4 * i), 5'(i), 32'(16 * i));
      tick();
    end
    chk("fullpp pre count", 32'(d1_count), 4);
    commit(32'h714, 5'd5, 32'h50);
    rd_ready = 1'b1;
    tick();
    clr_in();
    chk("fullpp count", 32'(d1_count), 4);
    chk("fullpp dropped", 32'(d1_dropped), 0);
    chk("fullpp state", 32'(d1_state), 2);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fullpp drain%0d", k), d1_rd_wdata, 32'(16 * (k + 2)));
      rd_ready = 1'b1;
      tick();
    end
    clr_in();
    chk("fullpp empty", 32'(d1_rd_valid), 0);

    // Reset while capturing with three entries held.
    do_arm(1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      commit(32'h800 + 32'(4 * i), 5'(i), 32'(i));
      tick();
    end
    clr_in();
    chk("prereset d0 count", 32'(d0_count), 3);
    chk("prereset d1 count", 32'(d1_count), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_dut(0, "midreset", 0, 0, 0, 0, 0, 0, 0);
    chk_dut(1, "midreset", 0, 0, 0, 0, 0, 0, 0);

    // Random traffic against the queue model; first cycle resets both sides into sync.
    for (int c = 0; c < 3000; c++) begin
      reset     = (c == 0) || ($urandom_range(0, 299) == 0);
      arm       = ($urandom_range(0, 39) == 0);
      trig_en   = 1'($urandom_range(0, 1));
      trig_pc   = 32'h3000 + 32'(4 * $urandom_range(0, 7));
      cmt_valid = ($urandom_range(0, 9) < 7);
      cmt_pc    = 32'h3000 + 32'(4 * $urandom_range(0, 7));
      cmt_we    = ($urandom_range(0, 9) < 8);
      cmt_waddr = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cmt_wdata = $urandom;
      rd_ready  = (c < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      model_step(0);
      model_step(1);
      tick();
      for (int w = 0; w < 2; w++) begin
        ent_t h;
        int   n;
        h = '0;
        if (w == 0) begin
          n = mq0.size();
          if (n != 0) h = mq0[0];
        end else begin
          n = mq1.size();
          if (n != 0) h = mq1[0];
        end
        chk_dut(w, $sformatf("rnd%0d", c), 32'(n), 32'(mst[w]), 32'(mdr[w]),
                32'(n != 0), h.pc, 32'(h.wa), h.wd);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
